// File: rtl/mult_batch_seq_pkg.sv
// rtl/mult_batch_seq_pkg.sv - shared state encodings and timing helper for mult_batch_seq (macro: SIGNED_MULT_EN)
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_MULT   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Two operand fetches, DATA_W multiply steps, one write.
  function automatic int unsigned pair_latency(input int unsigned data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/mult_batch_seq_if.sv
// rtl/mult_batch_seq_if.sv - operand ROM read port and result RAM write port (macro: SIGNED_MULT_EN)
interface mult_batch_seq_if #(
  parameter int DATA_W = 4,
  parameter int ROM_AW = 3,
  parameter int RAM_AW = 3
);
  logic [ROM_AW-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_data;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_addr;
  logic [2*DATA_W-1:0] ram_wdata;

  modport master (
    output rom_addr,
    input  rom_data,
    output ram_we,
    output ram_addr,
    output ram_wdata
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata
  );
endinterface

// File: rtl/mult_batch_seq_shift_add_mult.sv
// rtl/mult_batch_seq_shift_add_mult.sv - one-bit-per-cycle shift-add multiplier (macro: SIGNED_MULT_EN)
module shift_add_mult #(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
`ifdef SIGNED_MULT_EN
  input  logic                is_signed,
`endif
  output logic                busy,
  output logic                valid,
  output logic [2*DATA_W-1:0] p
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand_q;
  logic [2*DATA_W-1:0] p_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [CW-1:0]       bit_q;
  logic                busy_q;
  logic                valid_q;
  logic                sgn_q;
  logic                load_sgn;
  logic                last_step;

`ifdef SIGNED_MULT_EN
  assign load_sgn = is_signed;
`else
  assign load_sgn = 1'b0;
`endif

  assign last_step = (bit_q == CW'(DATA_W - 1));

  // Signed: the multiplier MSB carries weight -2^(DATA_W-1), so its partial product is subtracted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_q  <= '0;
      p_q      <= '0;
      mplier_q <= '0;
      bit_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sgn_q    <= 1'b0;
    end else if (load) begin
      mcand_q  <= {{DATA_W{a[DATA_W-1] & load_sgn}}, a};
      p_q      <= '0;
      mplier_q <= b;
      bit_q    <= '0;
      busy_q   <= 1'b1;
      valid_q  <= 1'b0;
      sgn_q    <= load_sgn;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        p_q <= (last_step && sgn_q) ? p_q - mcand_q : p_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      bit_q    <= bit_q + CW'(1);
      if (last_step) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign p     = p_q;

endmodule

// File: rtl/mult_batch_seq.sv
// rtl/mult_batch_seq.sv - batch ROM->multiply->RAM sequencer top (macro: SIGNED_MULT_EN adds is_signed)
module mult_batch_seq
  import mult_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ROM_AW = 3,
  parameter int RAM_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] src_base,
  input  logic [RAM_AW-1:0] dst_base,
  input  logic [RAM_AW:0]   count,
`ifdef SIGNED_MULT_EN
  input  logic              is_signed,
`endif
  mult_batch_seq_if.master  mem,
  output logic              busy,
  output logic              done,
  output logic [2:0]        st_debug
);

  localparam int KW = RAM_AW + 1;
  localparam int CW = $clog2(DATA_W + 1);

  state_e              state_q;
  logic [ROM_AW-1:0]   rom_addr_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic [RAM_AW-1:0]   dst_q;
  logic [KW-1:0]       cnt_q;
  logic [KW-1:0]       k_q;
  logic [DATA_W-1:0]   a_q;
  logic [CW-1:0]       bit_q;
  logic                ram_we_q;
  logic                busy_q;
  logic                done_q;
  logic                sgn_q;
  logic                mult_busy;
  logic                mult_valid;
  logic [2*DATA_W-1:0] mult_p;
  logic                unused_mult;

  assign unused_mult = mult_busy ^ mult_valid;

  shift_add_mult #(.DATA_W(DATA_W)) u_mult (
    .clk       (clk),
    .reset     (reset),
    .load      (state_q == ST_LOAD_B),
    .a         (a_q),
    .b         (mem.rom_data),
`ifdef SIGNED_MULT_EN
    .is_signed (sgn_q),
`endif
    .busy      (mult_busy),
    .valid     (mult_valid),
    .p         (mult_p)
  );

  // rom_addr_q doubles as the operand pointer: +1 after each fetch walks src_base+2k, +2k+1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      a_q        <= '0;
      bit_q      <= '0;
      ram_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sgn_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
`ifdef SIGNED_MULT_EN
            sgn_q  <= is_signed;
`endif
            if (count != '0) begin
              rom_addr_q <= src_base;
              dst_q      <= dst_base;
              cnt_q      <= count;
              k_q        <= '0;
              state_q    <= ST_LOAD_A;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_LOAD_A: begin
          a_q        <= mem.rom_data;
          rom_addr_q <= rom_addr_q + ROM_AW'(1);
          state_q    <= ST_LOAD_B;
        end
        ST_LOAD_B: begin
          bit_q   <= '0;
          state_q <= ST_MULT;
        end
        ST_MULT: begin
          bit_q <= bit_q + CW'(1);
          if (bit_q == CW'(DATA_W - 1)) begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= dst_q + k_q[RAM_AW-1:0];
            state_q    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          ram_we_q   <= 1'b0;
          k_q        <= k_q + KW'(1);
          rom_addr_q <= rom_addr_q + ROM_AW'(1);
          if (k_q + KW'(1) == cnt_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_LOAD_A;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem.rom_addr  = rom_addr_q;
  assign mem.ram_we    = ram_we_q;
  assign mem.ram_addr  = ram_addr_q;
  assign mem.ram_wdata = mult_p;
  assign busy          = busy_q;
  assign done          = done_q;
  assign st_debug      = state_q;

endmodule

// File: tb/tb_mult_batch_seq.sv
// tb/tb_mult_batch_seq.sv - self-checking bench for mult_batch_seq (macro: SIGNED_MULT_EN)
module tb_mult_batch_seq;

  localparam int W   = 4;
  localparam int LAT = W + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] src_base;
  logic [2:0] dst_base;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [2:0] st_debug;
`ifdef SIGNED_MULT_EN
  logic       is_signed;
`endif

  always #5 clk = ~clk;

  mult_batch_seq_if #(.DATA_W(4), .ROM_AW(3), .RAM_AW(3)) mem ();

  logic [3:0] rom [8];
  logic [7:0] ram [8];
  logic [7:0] exp_ram [8];
  assign mem.rom_data = rom[mem.rom_addr];

  mult_batch_seq #(.DATA_W(4), .ROM_AW(3), .RAM_AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .count     (count),
`ifdef SIGNED_MULT_EN
    .is_signed (is_signed),
`endif
    .mem       (mem.master),
    .busy      (busy),
    .done      (done),
    .st_debug  (st_debug)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] wr_addr [$];
  logic [7:0] wr_data [$];
  logic [2:0] ex_addr [$];
  logic [7:0] ex_data [$];
  int n_done = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (mem.ram_we) begin
      ram[mem.ram_addr] = mem.ram_wdata;
      wr_addr.push_back(mem.ram_addr);
      wr_data.push_back(mem.ram_wdata);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b, input bit sgn);
    int ia;
    int ib;
    ia = (sgn && a[3]) ? int'(a) - 16 : int'(a);
    ib = (sgn && b[3]) ? int'(b) - 16 : int'(b);
    return 8'(ia * ib);
  endfunction

  task automatic model_batch(input int s, input int d, input int n, input bit sgn);
    logic [7:0] pr;
    ex_addr.delete();
    ex_data.delete();
    for (int k = 0; k < n; k++) begin
      pr = ref_mul(rom[(s + 2*k) % 8], rom[(s + 2*k + 1) % 8], sgn);
      exp_ram[(d + k) % 8] = pr;
      ex_addr.push_back(3'((d + k) % 8));
      ex_data.push_back(pr);
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wr_addr.size(), ex_addr.size());
    for (int i = 0; i < ex_addr.size() && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_waddr%0d", tag, i), wr_addr[i], ex_addr[i]);
      chk($sformatf("%s_wdata%0d", tag, i), wr_data[i], ex_data[i]);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("%s_ram%0d", tag, i), ram[i], exp_ram[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rom_addr"}, mem.rom_addr, 0);
    chk({tag, "_ram_we"}, mem.ram_we, 0);
    chk({tag, "_ram_addr"}, mem.ram_addr, 0);
    chk({tag, "_ram_wdata"}, mem.ram_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state"}, st_debug, 0);
  endtask

  task automatic run_batch(input string tag, input int s, input int d, input int n,
                           input bit sgn, input int extra_at);
    int t;
    int guard;
    wr_addr.delete();
    wr_data.delete();
    n_done = 0;
    model_batch(s, d, n, sgn);
    @(negedge clk); #1;
    start    = 1'b1;
    src_base = 3'(s);
    dst_base = 3'(d);
    count    = 4'(n);
`ifdef SIGNED_MULT_EN
    is_signed = sgn;
`endif
    t = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_early"}, busy, 1);
    if (extra_at > 0) begin
      repeat (extra_at - 1) begin @(negedge clk); #1; end
      start    = 1'b1;
      src_base = ~3'(s);
      count    = 4'd1;
      @(negedge clk); #1;
      start = 1'b0;
    end
    guard = 0;
    while (n_done == 0 && guard < 300) begin
      @(negedge clk); #1;
      guard++;
    end
    chk({tag, "_done_seen"}, n_done, 1);
    chk({tag, "_done_cycle"}, done_cyc, t + 1 + n * LAT);
    @(negedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_idle_after"}, st_debug, 0);
    check_writes(tag);
  endtask

  initial begin
    int t;
    reset = 1'b0;
    start = 1'b0;
    src_base = '0;
    dst_base = '0;
    count = '0;
`ifdef SIGNED_MULT_EN
    is_signed = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      ram[i] = '0;
      exp_ram[i] = '0;
    end
    rom = '{4'd3, 4'd5, 4'd15, 4'd15, 4'd0, 4'd9, 4'd2, 4'd7};
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b1;

    run_batch("basic", 0, 0, 4, 1'b0, 0);
    chk("basic_c0", ram[0], 8'h0F);
    chk("basic_c1", ram[1], 8'hE1);
    chk("basic_c2", ram[2], 8'h00);
    chk("basic_c3", ram[3], 8'h0E);

    run_batch("wrap", 6, 7, 2, 1'b0, 0);
    chk("wrap_c7", ram[7], 8'h0E);
    chk("wrap_c0", ram[0], 8'h0F);

    run_batch("zero", 3, 2, 0, 1'b0, 0);

    run_batch("busy_start", 0, 4, 4, 1'b0, 4);

    run_batch("full", 1, 3, 8, 1'b0, 0);

    // Reset lands during the MULT phase of pair 1; only pair 0 may reach the RAM.
    wr_addr.delete();
    wr_data.delete();
    model_batch(2, 5, 1, 1'b0);
    @(negedge clk); #1;
    start = 1'b1; src_base = 3'd2; dst_base = 3'd5; count = 4'd4;
    t = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    while (cyc < t + 11) begin @(negedge clk); #1; end
    reset = 1'b0;
    @(negedge clk); #1;
    check_idle_outputs("midreset");
    reset = 1'b1;
    repeat (20) begin @(negedge clk); #1; end
    check_writes("midreset");

`ifdef SIGNED_MULT_EN
    rom[0] = 4'd7;
    rom[1] = 4'hD;
    run_batch("signed", 0, 0, 1, 1'b1, 0);
    chk("signed_c", ram[0], 8'hEB);
    run_batch("unsigned", 0, 1, 1, 1'b0, 0);
    chk("unsigned_c", ram[1], 8'h5B);
`endif

    for (int r = 0; r < 6; r++) begin
      bit sgn;
      for (int i = 0; i < 8; i++) rom[i] = 4'($urandom);
      sgn = 1'b0;
`ifdef SIGNED_MULT_EN
      sgn = 1'($urandom);
`endif
      run_batch($sformatf("rnd%0d", r), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 8)), sgn, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
